// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline hazard/control bundle between the core datapath and the hazard unit
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             ext_stall;
  logic             id_valid;
  logic             id_is_branch;
  logic             id_uses_rs2;
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic             br_eq;
  logic             ID_EX_reg_write;
  logic             ID_EX_mem_read;
  logic [4:0]       ID_EX_rd;
  logic             EX_MEM_reg_write;
  logic             EX_MEM_mem_read;
  logic [4:0]       EX_MEM_rd;
  logic             MEM_WB_reg_write;
  logic [4:0]       MEM_WB_rd;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             pc_sel;
  logic             ctrl_sel;
  logic [1:0]       forward_comp1;
  logic [1:0]       forward_comp2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // datapath side: supplies pipeline state, consumes control decisions
  modport master (
    output ext_stall, id_valid, id_is_branch, id_uses_rs2, IF_ID_rs1, IF_ID_rs2, br_eq,
           ID_EX_reg_write, ID_EX_mem_read, ID_EX_rd,
           EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_rd,
           MEM_WB_reg_write, MEM_WB_rd,
    input  pc_write, IF_ID_write, IF_ID_flush, pc_sel, ctrl_sel,
           forward_comp1, forward_comp2, stall_cnt, flush_cnt
  );

  // hazard unit side
  modport slave (
    input  ext_stall, id_valid, id_is_branch, id_uses_rs2, IF_ID_rs1, IF_ID_rs2, br_eq,
           ID_EX_reg_write, ID_EX_mem_read, ID_EX_rd,
           EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_rd,
           MEM_WB_reg_write, MEM_WB_rd,
    output pc_write, IF_ID_write, IF_ID_flush, pc_sel, ctrl_sel,
           forward_comp1, forward_comp2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall, flush, branch-redirect and ID compare forwarding sequencer
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  hazard_control_unit_if.slave  hz
);
  typedef enum logic {RUN = 1'b0, STALL2 = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             rs2_live;
  logic             ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic             ex_any, mem_any, taken;
  logic [1:0]       need;
  logic [1:0]       fwd1, fwd2;
  logic             stall_inc, flush_inc;

  // rs2 is only a real source for instructions that read it or compare it
  assign rs2_live = hz.id_uses_rs2 | hz.id_is_branch;

  assign ex_m1  = hz.id_valid & hz.ID_EX_reg_write  & (hz.ID_EX_rd  != 5'd0) & (hz.ID_EX_rd  == hz.IF_ID_rs1);
  assign ex_m2  = hz.id_valid & hz.ID_EX_reg_write  & (hz.ID_EX_rd  != 5'd0) & (hz.ID_EX_rd  == hz.IF_ID_rs2) & rs2_live;
  assign mem_m1 = hz.id_valid & hz.EX_MEM_reg_write & (hz.EX_MEM_rd != 5'd0) & (hz.EX_MEM_rd == hz.IF_ID_rs1);
  assign mem_m2 = hz.id_valid & hz.EX_MEM_reg_write & (hz.EX_MEM_rd != 5'd0) & (hz.EX_MEM_rd == hz.IF_ID_rs2) & rs2_live;
  assign wb_m1  = hz.id_valid & hz.MEM_WB_reg_write & (hz.MEM_WB_rd != 5'd0) & (hz.MEM_WB_rd == hz.IF_ID_rs1);
  assign wb_m2  = hz.id_valid & hz.MEM_WB_reg_write & (hz.MEM_WB_rd != 5'd0) & (hz.MEM_WB_rd == hz.IF_ID_rs2) & rs2_live;

  assign ex_any  = ex_m1 | ex_m2;
  assign mem_any = mem_m1 | mem_m2;
  assign taken   = hz.id_valid & hz.id_is_branch & hz.br_eq;

  // number of bubbles the instruction in ID must wait; branches compare in ID so they wait longer
  always_comb begin
    need = 2'd0;
    if (!hz.id_is_branch) begin
      if (hz.ID_EX_mem_read && ex_any) need = 2'd1;
    end else if (ex_any) begin
      need = hz.ID_EX_mem_read ? 2'd2 : 2'd1;
    end else if (mem_any && hz.EX_MEM_mem_read) begin
      need = 2'd1;
    end
  end

  // compare-operand bypass: an in-flight ALU result beats older writeback data; load data in MEM is not ready
  always_comb begin
    fwd1 = 2'b00;
    fwd2 = 2'b00;
    if (mem_m1 && !hz.EX_MEM_mem_read) fwd1 = 2'b01;
    else if (wb_m1)                    fwd1 = 2'b10;
    if (mem_m2 && !hz.EX_MEM_mem_read) fwd2 = 2'b01;
    else if (wb_m2)                    fwd2 = 2'b10;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // next state: a load feeding a branch takes a forced second bubble; external freeze holds position
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (!hz.ext_stall && need == 2'd2) state_nxt = STALL2;
      STALL2:  if (!hz.ext_stall) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // control outputs and counter increment requests; reset forces everything quiet
  always_comb begin
    hz.pc_write      = 1'b0;
    hz.IF_ID_write   = 1'b0;
    hz.IF_ID_flush   = 1'b0;
    hz.pc_sel        = 1'b0;
    hz.ctrl_sel      = 1'b0;
    hz.forward_comp1 = 2'b00;
    hz.forward_comp2 = 2'b00;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    if (!reset) begin
      hz.forward_comp1 = fwd1;
      hz.forward_comp2 = fwd2;
      if (state == STALL2) begin
        stall_inc = !hz.ext_stall;
      end else if (hz.ext_stall) begin
        stall_inc = 1'b0;
      end else if (need != 2'd0) begin
        stall_inc = 1'b1;
      end else begin
        hz.pc_write    = 1'b1;
        hz.IF_ID_write = 1'b1;
        hz.ctrl_sel    = 1'b1;
        if (taken) begin
          hz.pc_sel      = 1'b1;
          hz.IF_ID_flush = 1'b1;
          flush_inc      = 1'b1;
        end
      end
    end
  end

  // saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule
